// File: rtl/mcnt_scan_ssd.sv
// -----------------------------------------------------------------------------
// mcnt_scan_ssd
//
// Purpose:
//   A multi-digit up/down counter driving a time-multiplexed seven-segment
//   display. The counter is one chain of DIGITS nibbles. It can run in hex
//   radix (0..F per digit) or BCD radix (0..9 per digit). Counting advances
//   on a clock-enable tick taken from a free-running divider. The display
//   steps through the anodes from a second divider and can blank leading
//   zero digits. The block uses a single clock and derives no clocks.
//
// Parameters:
//   DIGITS    number of nibble digits and anodes (1..8)
//   TICK_DIV  clk cycles per count tick (>= 2)
//   SCAN_DIV  clk cycles per scan step (>= 2)
//
// Ports:
//   mcnt_scan_ssd_clk    in   1         system clock
//   mcnt_scan_ssd_rst    in   1         asynchronous reset, active high
//   mcnt_scan_ssd_en     in   1         count enable, sampled on tick
//   mcnt_scan_ssd_mode   in   1         0 = hex radix, 1 = BCD radix
//   mcnt_scan_ssd_dir    in   1         0 = up, 1 = down
//   mcnt_scan_ssd_lzb    in   1         1 = blank leading zero digits
//   mcnt_scan_ssd_count  out  4*DIGITS  counter value, digit 0 in [3:0]
//   mcnt_scan_ssd_wrap   out  1         one-cycle pulse on full-chain wrap
//   mcnt_scan_ssd_cc     out  7         cathodes, active low, bit0=a..bit6=g
//   mcnt_scan_ssd_an     out  DIGITS    anodes, active low, one-hot-low
//
// This block has no handshakes. All inputs are treated as synchronous to
// mcnt_scan_ssd_clk. Any synchronising or debouncing is done upstream.
// -----------------------------------------------------------------------------
module mcnt_scan_ssd #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 10000000,
    parameter int SCAN_DIV = 100000
) (
    input  logic                  mcnt_scan_ssd_clk,
    input  logic                  mcnt_scan_ssd_rst,
    input  logic                  mcnt_scan_ssd_en,
    input  logic                  mcnt_scan_ssd_mode,
    input  logic                  mcnt_scan_ssd_dir,
    input  logic                  mcnt_scan_ssd_lzb,
    output logic [4*DIGITS-1:0]   mcnt_scan_ssd_count,
    output logic                  mcnt_scan_ssd_wrap,
    output logic [6:0]            mcnt_scan_ssd_cc,
    output logic [DIGITS-1:0]     mcnt_scan_ssd_an
);

    localparam int TDIV_W = $clog2(TICK_DIV);
    localparam int SDIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [TDIV_W-1:0] TDIV_LAST = TDIV_W'(TICK_DIV - 1);
    localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    // During reset, digit 0 is lit and shows the pattern for "0".
    localparam logic [DIGITS-1:0] AN_RST = ~DIGITS'(1);
    localparam logic [6:0]        CC_RST = 7'b1000000;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [TDIV_W-1:0]   tdiv_q;
    logic [SDIV_W-1:0]   sdiv_q;
    logic [IDX_W-1:0]    idx_q;
    logic [4*DIGITS-1:0] count_q;
    logic                wrap_q;
    logic                mode_q;
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          cc_q;

    // ------------------------------------------------------------------
    // Seven-segment decode, gfedcba, active low
    // ------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Divider terminal counts
    // ------------------------------------------------------------------
    logic tick;
    logic scan_step;

    assign tick      = (tdiv_q == TDIV_LAST);
    assign scan_step = (sdiv_q == SDIV_LAST);

    // ------------------------------------------------------------------
    // Counter chain next value.
    // Carry in to digit 0 is always 1, so the chain increments or
    // decrements by one. A digit passes the carry on only when it rolls
    // over. The carry out of the top digit is a full-chain wrap.
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] count_nxt;
    logic                chain_wrap;
    logic [3:0]          dig_max;
    logic [3:0]          dig;
    logic                carry;

    assign dig_max = mode_q ? 4'h9 : 4'hF;

    always_comb begin
        count_nxt = count_q;
        carry     = 1'b1;
        dig       = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = count_q[i*4 +: 4];
            if (carry) begin
                if (!mcnt_scan_ssd_dir) begin
                    if (dig == dig_max) begin
                        count_nxt[i*4 +: 4] = 4'h0;
                    end else begin
                        count_nxt[i*4 +: 4] = dig + 4'd1;
                        carry               = 1'b0;
                    end
                end else begin
                    if (dig == 4'h0) begin
                        count_nxt[i*4 +: 4] = dig_max;
                    end else begin
                        count_nxt[i*4 +: 4] = dig - 4'd1;
                        carry               = 1'b0;
                    end
                end
            end
        end
        chain_wrap = carry;
    end

    // ------------------------------------------------------------------
    // Leading-zero detection.
    // zero_from[i] is set when digit i and every digit above it are 0.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] zero_from;
    logic              all_zero;

    always_comb begin
        zero_from = '0;
        all_zero  = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (count_q[i*4 +: 4] != 4'h0) begin
                all_zero = 1'b0;
            end
            zero_from[i] = all_zero;
        end
    end

    // ------------------------------------------------------------------
    // Scan mux: select the current digit and build the anode pattern.
    // Digit 0 is never blanked, so a value of zero still shows "0".
    // ------------------------------------------------------------------
    logic [3:0]        cur_digit;
    logic [DIGITS-1:0] an_nxt;

    always_comb begin
        cur_digit = 4'h0;
        an_nxt    = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = count_q[i*4 +: 4];
                if (!(mcnt_scan_ssd_lzb && (i != 0) && zero_from[i])) begin
                    an_nxt[i] = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge mcnt_scan_ssd_clk or posedge mcnt_scan_ssd_rst) begin
        if (mcnt_scan_ssd_rst) begin
            tdiv_q  <= '0;
            sdiv_q  <= '0;
            idx_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            // Track the mode pin through reset, so the first edge after
            // release does not see a spurious mode change.
            mode_q  <= mcnt_scan_ssd_mode;
            an_q    <= AN_RST;
            cc_q    <= CC_RST;
        end else begin
            // Tick divider runs freely, whatever the value of en.
            tdiv_q <= tick ? '0 : tdiv_q + TDIV_W'(1);

            // Scan divider and digit index.
            if (scan_step) begin
                sdiv_q <= '0;
                idx_q  <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                sdiv_q <= sdiv_q + SDIV_W'(1);
            end

            // A radix change clears the chain. This takes priority over a
            // tick on the same edge, so the new radix never sees a digit
            // that is illegal for it.
            mode_q <= mcnt_scan_ssd_mode;
            wrap_q <= 1'b0;
            if (mcnt_scan_ssd_mode != mode_q) begin
                count_q <= '0;
            end else if (tick && mcnt_scan_ssd_en) begin
                count_q <= count_nxt;
                wrap_q  <= chain_wrap;
            end

            // Display register, one cycle behind idx and count.
            an_q <= an_nxt;
            cc_q <= seg_decode(cur_digit);
        end
    end

    assign mcnt_scan_ssd_count = count_q;
    assign mcnt_scan_ssd_wrap  = wrap_q;
    assign mcnt_scan_ssd_an    = an_q;
    assign mcnt_scan_ssd_cc    = cc_q;

endmodule

// File: tb/tb_mcnt_scan_ssd.sv
module tb_mcnt_scan_ssd;

    localparam int DIGITS   = 4;
    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst;
    logic        en;
    logic        mode;
    logic        dir;
    logic        lzb;
    logic [15:0] count;
    logic        wrap;
    logic [6:0]  cc;
    logic [3:0]  an;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mcnt_scan_ssd #(
        .DIGITS   (DIGITS),
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .mcnt_scan_ssd_clk   (clk),
        .mcnt_scan_ssd_rst   (rst),
        .mcnt_scan_ssd_en    (en),
        .mcnt_scan_ssd_mode  (mode),
        .mcnt_scan_ssd_dir   (dir),
        .mcnt_scan_ssd_lzb   (lzb),
        .mcnt_scan_ssd_count (count),
        .mcnt_scan_ssd_wrap  (wrap),
        .mcnt_scan_ssd_cc    (cc),
        .mcnt_scan_ssd_an    (an)
    );

    // ---------------- scoreboard counters ----------------
    int checks    = 0;
    int failures  = 0;
    int wrap_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // The count is kept as a plain integer in the current radix. Digits,
    // blanking and wrap all come from integer arithmetic on it.
    logic [6:0] seg_tab [16];
    int         m_ecnt;
    int         m_val;
    logic       m_mode_q;
    logic       m_wrap;
    logic [3:0] m_an;
    logic [6:0] m_cc;

    function automatic int radix(input logic md);
        return md ? 10 : 16;
    endfunction

    function automatic int span(input logic md);
        int s = 1;
        for (int i = 0; i < DIGITS; i++) s = s * radix(md);
        return s;
    endfunction

    function automatic logic [15:0] to_nib(input int v, input logic md);
        logic [15:0] r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[i*4 +: 4] = 4'(v % radix(md));
            v = v / radix(md);
        end
        return r;
    endfunction

    task automatic model_reset();
        m_ecnt   = 0;
        m_val    = 0;
        m_mode_q = mode;
        m_wrap   = 1'b0;
        m_an     = 4'b1110;
        m_cc     = 7'b1000000;
    endtask

    task automatic model_edge();
        int b;
        int idx;
        int hi;
        b   = radix(m_mode_q);
        idx = (m_ecnt / SCAN_DIV) % DIGITS;
        hi  = m_val;
        for (int i = 0; i < idx; i++) hi = hi / b;
        m_cc = seg_tab[hi % b];
        m_an = 4'hF;
        if (!(lzb && idx > 0 && hi == 0)) m_an[idx] = 1'b0;
        m_ecnt++;
        m_wrap = 1'b0;
        if (mode != m_mode_q) begin
            m_mode_q = mode;
            m_val    = 0;
        end else if ((m_ecnt % TICK_DIV) == 0 && en) begin
            if (!dir) begin
                m_val++;
                if (m_val == span(m_mode_q)) begin
                    m_val  = 0;
                    m_wrap = 1'b1;
                end
            end else if (m_val == 0) begin
                m_val  = span(m_mode_q) - 1;
                m_wrap = 1'b1;
            end else begin
                m_val--;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: the model steps on the rising edge, the DUT is compared on
    // the falling edge, and inputs change only after this task returns.
    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        chk("count", 32'(count), 32'(to_nib(m_val, m_mode_q)));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        chk("an", 32'(an), 32'(m_an));
        chk("cc", 32'(cc), 32'(m_cc));
        if (wrap) wrap_seen++;
    endtask

    // Reset asserted between edges, checked before the next edge.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk({tag, "_an"}, 32'(an), 32'h0000_000E);
        chk({tag, "_cc"}, 32'(cc), 32'h0000_0040);
        chk({tag, "_count"}, 32'(count), 32'h0);
        chk({tag, "_wrap"}, 32'(wrap), 32'h0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        mode;
        logic        dir;
        logic        en;
        int          ncyc;
        logic [15:0] exp_count;
        int          exp_wraps;
    } vec_t;

    vec_t vecs [$];

    logic [3:0] lzb_an   [4];
    logic [3:0] nolzb_an [4];

    initial begin
        int n;
        int ph;
        vec_t v;

        seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        lzb_an   = '{4'b1110, 4'b1111, 4'b1111, 4'b1111};
        nolzb_an = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // mode, dir, en, cycles, expected count, expected wrap pulses
        vecs.push_back('{1'b0, 1'b0, 1'b1, 3,     16'h0000, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 1,     16'h0001, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4,     16'h0002, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 12,    16'hFFFF, 1});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4,     16'hFFFE, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4,     16'hFFFF, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4,     16'h0000, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4,     16'h9999, 1});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4,     16'h9998, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4,     16'h9999, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4,     16'h0000, 1});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 400,   16'h0100, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b1, 4,     16'h0099, 0});
        vecs.push_back('{1'b1, 1'b1, 1'b0, 16,    16'h0099, 0});
        vecs.push_back('{1'b0, 1'b1, 1'b1, 4,     16'hFFFF, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 4,     16'h0000, 1});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 10572, 16'h0A53, 0});
        vecs.push_back('{1'b0, 1'b0, 1'b1, 3,     16'h0A53, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 1,     16'h0000, 0});
        vecs.push_back('{1'b1, 1'b0, 1'b1, 4,     16'h0001, 0});

        // ---------------- power-on reset ----------------
        rst  = 1'b1;
        en   = 1'b0;
        mode = 1'b0;
        dir  = 1'b0;
        lzb  = 1'b0;
        model_reset();
        @(negedge clk);
        chk("por_an", 32'(an), 32'h0000_000E);
        chk("por_cc", 32'(cc), 32'h0000_0040);
        chk("por_count", 32'(count), 32'h0);
        chk("por_wrap", 32'(wrap), 32'h0);
        cyc();
        rst = 1'b0;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            v         = vecs[i];
            mode      = v.mode;
            dir       = v.dir;
            en        = v.en;
            lzb       = 1'b0;
            wrap_seen = 0;
            repeat (v.ncyc) cyc();
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(v.exp_count));
            chk($sformatf("vec%0d_wraps", i), 32'(wrap_seen), 32'(v.exp_wraps));
        end

        // ---------------- blanking scan sequence ----------------
        mode = 1'b0;
        dir  = 1'b0;
        en   = 1'b0;
        async_reset("rst_a");
        en = 1'b1;
        n  = 0;
        repeat (28) begin
            cyc();
            n++;
        end
        chk("seven_count", 32'(count), 32'h0007);
        en  = 1'b0;
        lzb = 1'b1;
        repeat (8) begin
            cyc();
            n++;
            ph = ((n - 1) / SCAN_DIV) % DIGITS;
            chk($sformatf("lzb_an_ph%0d", ph), 32'(an), 32'(lzb_an[ph]));
            if (ph == 0) chk("lzb_cc_ph0", 32'(cc), 32'h0000_0078);
        end
        lzb = 1'b0;
        repeat (8) begin
            cyc();
            n++;
            ph = ((n - 1) / SCAN_DIV) % DIGITS;
            chk($sformatf("nolzb_an_ph%0d", ph), 32'(an), 32'(nolzb_an[ph]));
            chk($sformatf("nolzb_cc_ph%0d", ph), 32'(cc), (ph == 0) ? 32'h78 : 32'h40);
        end

        // ---------------- reset with idx=2 and the tick divider mid-count ----------------
        en = 1'b1;
        for (int k = 0; k < 8 && (n % 8) != 5; k++) begin
            cyc();
            n++;
        end
        chk("pre_reset_phase", 32'(n % 8), 32'd5);
        async_reset("rst_mid");

        // ---------------- en low holds the count ----------------
        en = 1'b1;
        repeat (8) cyc();
        chk("hold_pre", 32'(count), 32'h0002);
        en        = 1'b0;
        wrap_seen = 0;
        repeat (16) cyc();
        chk("hold_count", 32'(count), 32'h0002);
        chk("hold_wraps", 32'(wrap_seen), 32'd0);

        // ---------------- randomized run against the model ----------------
        for (int r = 0; r < 3000; r++) begin
            en  = ($urandom_range(0, 3) != 0);
            dir = $urandom_range(0, 1) == 1;
            lzb = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 199) == 0) mode = ~mode;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
